channel_isi_model: RTL and testbench
====================================

# channel_isi_model

Channel stage that consumes the PAM-4 voltage-level stream and produces the received-signal stream. It applies a 4-tap FIR model of inter-symbol interference, with runtime-programmable tap weights, plus optional pseudo-random noise, then saturates. It sits between the PAM-4 encoder and the receiver/slicer in the simulation chain.

## Interface
Parameters:
- `NOISE_BITS`, default 3: width of signed noise term added per sample (range -2^(NOISE_BITS-1) .. 2^(NOISE_BITS-1)-1); legal 1..8.
- `LFSR_SEED`, default 16'hACE1: non-zero reset value of noise LFSR.

Ports:
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `voltage_level_in` input 8: signed two's-complement sample (PAM-4 levels e.g. -84/-28/28/84).
- `voltage_level_in_valid` input 1: sample qualifier.
- `tap0`..`tap3` input 8 each: signed Q1.6 weights (64 = 1.0) for x[n], x[n-1], x[n-2], x[n-3].
- `noise_en` input 1: 1 = add noise term.
- `voltage_level_out` output 8: signed received sample.
- `voltage_level_out_valid` output 1: output qualifier.

## Operation
- History register x[0..3] (x[0] newest), 8-bit signed each.
- On valid input: x[0] ← input, x[k] ← x[k-1]; otherwise history holds. Bubbles do not advance the channel.
- Stage 1, registered on the valid input cycle:
  - p_k = tap_k × x[k], 16-bit signed, computed from the updated history, so the new sample is x[0].
  - Noise term captured.
- Stage 2, registered:
  - sum = p0+p1+p2+p3, 18-bit signed.
  - s = sum >>> 6: arithmetic shift, floor rounding.
  - If noise_en was 1 at input time, add sign-extended noise.
  - Saturate to [-128, 127].
- Noise source: 16-bit Fibonacci LFSR, taps 16,14,13,11, x^16+x^14+x^13+x^11+1.
  - Steps once per valid input only.
  - Noise = low NOISE_BITS bits of LFSR state, interpreted signed, sampled before the step.
  - LFSR steps regardless of noise_en, so the sequence is independent of enable toggling.
- Tap and noise_en values are sampled in the same cycle as the input sample; mid-stream changes affect only later samples.

## Timing
- Latency: sample valid in cycle N → voltage_level_out_valid high in cycle N+2 with its result. Fixed, no backpressure.
- Throughput: one sample per cycle. Output valid pattern equals input valid pattern delayed by 2.
- Reset values:
  - voltage_level_out = 0, voltage_level_out_valid = 0.
  - History and pipeline products = 0.
  - LFSR = LFSR_SEED.
- Reset mid-stream: samples in flight are discarded. voltage_level_out_valid is 0 in the cycle after reset asserts and stays 0 until 2 cycles after the first post-reset valid input. The first post-reset output sees zero history.
- Reset has priority over voltage_level_in_valid in the same cycle; that input sample is dropped.
- Startup: the first three samples after reset include zeroed history terms; no warm-up suppression.

## Test plan
- Identity: tap0=64, other taps 0, noise_en=0; inputs 84, -28, 28, -84 back-to-back → outputs 84, -28, 28, -84, each 2 cycles after its input, valid contiguous.
- ISI postcursor: tap0=64, tap1=16, others 0; inputs 84, 84, -84 → outputs 84, 105, -63.
- Saturation and floor:
  - tap0=127, input 127 → out 127.
  - tap0=127, input -128 → out -128.
  - tap0=1, input -1 → out -1; input 1 → out 0.
- Bubbles: tap1=64, others 0; input 84, then 3 invalid cycles, then input 28 → outputs 0 then 84. Valid high only 2 cycles after each input. History does not shift on bubbles.
- Noise:
  - tap0=64, noise_en=1, NOISE_BITS=3, constant input 28 for 16 samples.
  - Each output = 28 + signed(low 3 LFSR bits) per the golden LFSR model from seed 16'hACE1.
  - Repeating the run with noise_en=0 yields constant 28, and the LFSR sequence is unchanged when noise is re-enabled.
- Reset mid-stream: assert rst while two samples are in flight → no output valid emitted for them, out=0. Next input 84 with tap0=64, tap1=64 → output 84 (zero history), not 84 plus the old sample.

Source files
------------

// File: rtl/channel_isi_model.sv
// channel_isi_model
//   Channel stage between the PAM-4 encoder and the receiver/slicer. It applies
//   a 4-tap FIR inter-symbol-interference model with runtime tap weights, adds
//   optional LFSR noise, and saturates the result to 8 bits.
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   voltage_level_in         signed 8-bit input sample
//   voltage_level_in_valid   input sample qualifier
//   tap0..tap3               signed Q1.6 weights for x[n]..x[n-3] (64 = 1.0)
//   noise_en                 1 = add the noise term to this sample
//   voltage_level_out        signed 8-bit received sample
//   voltage_level_out_valid  output qualifier, input valid delayed by 2 cycles
module channel_isi_model #(
   parameter int          NOISE_BITS = 3,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic signed [7:0] voltage_level_in,
   input  logic              voltage_level_in_valid,
   input  logic signed [7:0] tap0,
   input  logic signed [7:0] tap1,
   input  logic signed [7:0] tap2,
   input  logic signed [7:0] tap3,
   input  logic              noise_en,
   output logic signed [7:0] voltage_level_out,
   output logic              voltage_level_out_valid
);

   localparam int DATA_W = 8;
   localparam int COEF_W = 8;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int SUM_W  = PROD_W + 2;
   localparam int FRAC   = 6;

   function automatic logic signed [PROD_W-1:0] mul(input logic signed [COEF_W-1:0] c,
                                                   input logic signed [DATA_W-1:0] d);
      logic signed [PROD_W-1:0] ce;
      logic signed [PROD_W-1:0] de;
      ce = PROD_W'(c);
      de = PROD_W'(d);
      return ce * de;
   endfunction

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] v);
      if (v > 127)
         return 8'sd127;
      else if (v < -128)
         return -8'sd128;
      else
         return v[DATA_W-1:0];
   endfunction

   // Right-shifting Fibonacci form: taps 16,14,13,11 of the polynomial sit at
   // bit positions 0,2,3,5, feedback enters at bit 15.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   logic signed [DATA_W-1:0]     hist [4];
   logic signed [PROD_W-1:0]     prod_p1 [4];
   logic signed [NOISE_BITS-1:0] noise_p1;
   logic                         noise_en_p1;
   logic                         vld_p1;
   logic [15:0]                  lfsr;

   // Stage 1: history shift, products against the updated history, noise capture.
   // Bubbles leave history, products and the LFSR untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            hist[k]    <= '0;
            prod_p1[k] <= '0;
         end
         noise_p1    <= '0;
         noise_en_p1 <= 1'b0;
         vld_p1      <= 1'b0;
         lfsr        <= LFSR_SEED;
      end else begin
         vld_p1 <= voltage_level_in_valid;
         if (voltage_level_in_valid) begin
            hist[0]     <= voltage_level_in;
            hist[1]     <= hist[0];
            hist[2]     <= hist[1];
            hist[3]     <= hist[2];
            prod_p1[0]  <= mul(tap0, voltage_level_in);
            prod_p1[1]  <= mul(tap1, hist[0]);
            prod_p1[2]  <= mul(tap2, hist[1]);
            prod_p1[3]  <= mul(tap3, hist[2]);
            // Noise uses the state before this sample's step; the LFSR advances
            // even with noise disabled so the sequence ignores enable toggling.
            noise_p1    <= lfsr[NOISE_BITS-1:0];
            noise_en_p1 <= noise_en;
            lfsr        <= lfsr_step(lfsr);
         end
      end
   end

   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] scaled;
   logic signed [SUM_W-1:0] noise_ext;
   logic signed [SUM_W-1:0] noisy;

   always_comb begin
      sum       = SUM_W'(prod_p1[0]) + SUM_W'(prod_p1[1])
                + SUM_W'(prod_p1[2]) + SUM_W'(prod_p1[3]);
      // Arithmetic shift floors toward minus infinity (-1/64 -> -1).
      scaled    = sum >>> FRAC;
      noise_ext = noise_en_p1 ? SUM_W'(noise_p1) : '0;
      noisy     = scaled + noise_ext;
   end

   // Stage 2: accumulate, rescale, noise, saturate.
   always_ff @(posedge clk) begin
      if (rst) begin
         voltage_level_out       <= '0;
         voltage_level_out_valid <= 1'b0;
      end else begin
         voltage_level_out_valid <= vld_p1;
         if (vld_p1)
            voltage_level_out <= sat(noisy);
      end
   end

endmodule

// File: tb/tb_channel_isi_model.sv
// tb_channel_isi_model
//   Directed bench for channel_isi_model: identity, postcursor ISI, saturation
//   and floor rounding, bubbles, LFSR noise with enable toggling, and reset
//   while samples are in flight.
module tb_channel_isi_model;

   logic              clk = 1'b0;
   logic              rst;
   logic signed [7:0] vin;
   logic              vin_valid;
   logic signed [7:0] tap0, tap1, tap2, tap3;
   logic              noise_en;
   logic signed [7:0] vout;
   logic              vout_valid;

   channel_isi_model #(.NOISE_BITS(3), .LFSR_SEED(16'hACE1)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .voltage_level_in        (vin),
      .voltage_level_in_valid  (vin_valid),
      .tap0                    (tap0),
      .tap1                    (tap1),
      .tap2                    (tap2),
      .tap3                    (tap3),
      .noise_en                (noise_en),
      .voltage_level_out       (vout),
      .voltage_level_out_valid (vout_valid)
   );

   always #5 clk = ~clk;

   int    nvec = 0;
   int    nmis = 0;
   int    pend_v = 0;
   int    pend_d = 0;
   string pend_tag = "";
   logic [15:0] lfsr_m;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Golden LFSR: taps 16,14,13,11, right-shifting Fibonacci form.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   function automatic int noise_of(input logic [15:0] s);
      int n;
      n = int'(s[2:0]);
      if (n >= 4) n = n - 8;
      return n;
   endfunction

   // One clock: apply a sample (or bubble), then check the output belonging to
   // the previous step, which is exactly 2 edges after that step's sample.
   task automatic step(input logic v, input int din, input int expd, input string tag);
      vin_valid = v;
      vin       = 8'(din);
      @(posedge clk);
      #1;
      chk({pend_tag, "_vld"}, 32'(vout_valid), pend_v);
      if (pend_v != 0) chk(pend_tag, vout, pend_d);
      pend_v    = int'(v);
      pend_d    = expd;
      pend_tag  = tag;
      vin_valid = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst       = 1'b1;
      vin_valid = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_rst_vld"}, 32'(vout_valid), 0);
      chk({tag, "_rst_out"}, vout, 0);
      rst    = 1'b0;
      pend_v = 0;
      lfsr_m = 16'hACE1;
   endtask

   task automatic set_taps(input int a, input int b, input int c, input int d);
      tap0 = 8'(a);
      tap1 = 8'(b);
      tap2 = 8'(c);
      tap3 = 8'(d);
   endtask

   initial begin
      int e;
      rst = 1'b1; vin = '0; vin_valid = 1'b0; noise_en = 1'b0;
      set_taps(0, 0, 0, 0);
      lfsr_m = 16'hACE1;
      repeat (2) @(posedge clk);
      #1;
      chk("init_vld", 32'(vout_valid), 0);
      chk("init_out", vout, 0);
      rst = 1'b0;

      // Identity
      do_reset("id");
      set_taps(64, 0, 0, 0);
      step(1,  84,  84, "id0");
      step(1, -28, -28, "id1");
      step(1,  28,  28, "id2");
      step(1, -84, -84, "id3");
      step(0, 0, 0, "idle");
      step(0, 0, 0, "idle");

      // Postcursor ISI
      do_reset("isi");
      set_taps(64, 16, 0, 0);
      step(1,  84,  84, "isi0");
      step(1,  84, 105, "isi1");
      step(1, -84, -63, "isi2");
      step(0, 0, 0, "idle");
      step(0, 0, 0, "idle");

      // Saturation and floor rounding
      do_reset("sat");
      set_taps(127, 0, 0, 0);
      step(1,  127,  127, "sat_hi");
      step(1, -128, -128, "sat_lo");
      set_taps(1, 0, 0, 0);
      step(1, -1, -1, "floor_neg");
      step(1,  1,  0, "floor_pos");
      step(0, 0, 0, "idle");
      step(0, 0, 0, "idle");

      // Bubbles do not shift history
      do_reset("bub");
      set_taps(0, 64, 0, 0);
      step(1, 84, 0, "bub0");
      step(0, 0, 0, "bub_gap");
      step(0, 0, 0, "bub_gap");
      step(0, 0, 0, "bub_gap");
      step(1, 28, 84, "bub1");
      step(0, 0, 0, "idle");
      step(0, 0, 0, "idle");

      // Noise: enabled, disabled, re-enabled; model LFSR advances every sample
      do_reset("nz");
      set_taps(64, 0, 0, 0);
      noise_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         e = 28 + noise_of(lfsr_m);
         lfsr_m = lfsr_next(lfsr_m);
         step(1, 28, e, "noise_on");
      end
      noise_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         lfsr_m = lfsr_next(lfsr_m);
         step(1, 28, 28, "noise_off");
      end
      noise_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         e = 28 + noise_of(lfsr_m);
         lfsr_m = lfsr_next(lfsr_m);
         step(1, 28, e, "noise_re");
      end
      noise_en = 1'b0;
      step(0, 0, 0, "idle");
      step(0, 0, 0, "idle");

      // Reset while samples are in flight; the sample offered with reset is dropped
      do_reset("rm");
      set_taps(64, 0, 0, 0);
      step(1, 84, 84, "rm_a");
      step(1, 28, 28, "rm_b");
      rst       = 1'b1;
      vin_valid = 1'b1;
      vin       = 8'sd56;
      @(posedge clk);
      #1;
      chk("rm_flight_vld", 32'(vout_valid), 0);
      chk("rm_flight_out", vout, 0);
      rst = 1'b0;
      pend_v = 0;
      step(0, 0, 0, "rm_idle");
      chk("rm_idle_out", vout, 0);
      step(0, 0, 0, "rm_idle");
      chk("rm_idle_out", vout, 0);
      set_taps(64, 64, 0, 0);
      step(1, 84, 84, "rm_post");
      step(0, 0, 0, "idle");
      step(0, 0, 0, "idle");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
